// File: rtl/rx_command_exec_if.sv
// Command push interface between the RX command generator (master) and rx_command_exec (slave).
interface rx_command_exec_if;
  logic [31:0] command_i;
  logic [63:0] time_i;
  logic        store_command;

  modport master (output command_i, output time_i, output store_command);
  modport slave  (input  command_i, input  time_i, input  store_command);
endinterface

// File: rtl/rx_command_exec.sv
// RX command executor: queues {time,command} words and gates ADC samples against VITA time.
// Optional RX_CMD_LATE_ERR_EN: late timed commands are dropped with err_late instead of run at once.
module rx_command_exec #(
  parameter int CMD_FIFO_AW = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  rx_command_exec_if.slave     cmd,
  input  logic [63:0]          vita_time,
  input  logic                 sample_valid,
  output logic                 run,
  output logic                 sample_strobe,
  output logic                 sof,
  output logic                 eof,
  output logic                 cmd_done,
  output logic                 err_late,
  output logic                 err_chain,
  output logic                 cmd_overflow,
  output logic [CMD_FIFO_AW:0] fifo_level
);

  localparam int DEPTH = 1 << CMD_FIFO_AW;
  localparam logic [CMD_FIFO_AW-1:0] PTR_ONE = 1;
  localparam logic [CMD_FIFO_AW:0]   LVL_ONE = 1;
  localparam logic [CMD_FIFO_AW:0]   LVL_FULL = DEPTH[CMD_FIFO_AW:0];

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RUN = 2'd2} state_t;
  state_t state, state_nxt;

  logic [95:0]            mem [DEPTH];
  logic [95:0]            head;
  logic [CMD_FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [CMD_FIFO_AW:0]   level;
  logic                   push, pop, load, empty, full;
  logic                   head_stop, head_zero;

  logic                   imm_r, chain_r, reload_r;
  logic [27:0]            nl_r;
  logic [63:0]            time_r;
  logic [27:0]            count;
  logic                   last, eof_hit, abort, at_time, late;

  assign empty        = (level == '0);
  assign full         = (level == LVL_FULL);
  assign head         = mem[rd_ptr];
  assign head_stop    = head[28];
  assign head_zero    = (head[27:0] == 28'd0);
  assign push         = cmd.store_command & (~full | pop);
  assign cmd_overflow = cmd.store_command & full & ~pop;
  assign load         = pop & ~head_stop;
  assign fifo_level   = level;

  assign run           = (state == S_RUN);
  assign sample_strobe = run & sample_valid;
  assign last          = (count == (nl_r - 28'd1));
  assign eof_hit       = sample_strobe & last;
  assign sof           = sample_strobe & (count == 28'd0);
  assign eof           = eof_hit;
  assign abort         = run & ~empty & head_stop;
  assign at_time       = imm_r | (vita_time == time_r);
  assign late          = ~imm_r & (vita_time > time_r);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd.time_i, cmd.command_i};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      level <= level + LVL_ONE;
      else if (pop && !push) level <= level - LVL_ONE;
    end
  end

  // Command registers hold the active burst; a stop word is never loaded.
  always_ff @(posedge clk) begin
    if (load) begin
      imm_r    <= head[31];
      chain_r  <= head[30];
      reload_r <= head[29];
      nl_r     <= head[27:0];
      time_r   <= head[95:32];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 count <= 28'd0;
    else if (load || eof_hit)  count <= 28'd0;
    else if (sample_strobe)    count <= count + 28'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (!empty && !head_stop && !head_zero) state_nxt = S_WAIT;
      S_WAIT: begin
        if (at_time) state_nxt = S_RUN;
`ifdef RX_CMD_LATE_ERR_EN
        else if (late) state_nxt = S_IDLE;
`else
        else if (late) state_nxt = S_RUN;
`endif
      end
      S_RUN: begin
        // A queued stop wins over chaining, even on the eof sample.
        if (abort) state_nxt = S_IDLE;
        else if (eof_hit) begin
          if (!chain_r)              state_nxt = S_IDLE;
          else if (!reload_r && (empty || head_zero)) state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    pop       = 1'b0;
    cmd_done  = 1'b0;
    err_chain = 1'b0;
    err_late  = 1'b0;
    case (state)
      S_IDLE: begin
        pop      = ~empty;
        cmd_done = ~empty & (head_stop | head_zero);
      end
      S_WAIT: begin
`ifdef RX_CMD_LATE_ERR_EN
        err_late = ~at_time & late;
`endif
      end
      S_RUN: begin
        if (abort) begin
          pop      = 1'b1;
          cmd_done = 1'b1;
        end else if (eof_hit) begin
          if (!chain_r) cmd_done = 1'b1;
          else if (!reload_r) begin
            if (empty) err_chain = 1'b1;
            else begin
              pop      = 1'b1;
              cmd_done = head_zero;
            end
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rx_command_exec.sv
// Scoreboard bench for rx_command_exec: a transaction-level model predicts the event stream.
module tb_rx_command_exec;
  localparam int K_SAMP = 0, K_DONE = 1, K_CHAIN = 2, K_LATE = 3;

  typedef struct { int kind; bit sof; bit eof; } ev_t;
  typedef struct { logic [31:0] w; logic [63:0] t; bit late; } cmd_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] vita_time = 64'd1000;
  logic        sample_valid;
  logic        run, sample_strobe, sof, eof, cmd_done, err_late, err_chain, cmd_overflow;
  logic [3:0]  fifo_level;

  rx_command_exec_if cif ();

  rx_command_exec #(.CMD_FIFO_AW(3)) dut (
    .clk(clk), .reset(reset), .cmd(cif), .vita_time(vita_time), .sample_valid(sample_valid),
    .run(run), .sample_strobe(sample_strobe), .sof(sof), .eof(eof), .cmd_done(cmd_done),
    .err_late(err_late), .err_chain(err_chain), .cmd_overflow(cmd_overflow),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) vita_time <= vita_time + 64'd1;

  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];
  bit   ovf_q[$];
  cmd_t scn[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic expect_ev(input int kind, input bit s, input bit e, input string name);
    ev_t x;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_%s actual=1 required=0 at %0t", name, $time);
    end else begin
      x = exp_q.pop_front();
      check({name, "_kind"}, kind, x.kind);
      if (kind == K_SAMP) begin
        check("sof", s, x.sof);
        check("eof", e, x.eof);
      end
    end
  endtask

  // Monitor: every DUT event consumes the next predicted event.
  always @(negedge clk) begin
    if (!reset) begin
      check("sof_eof_qualified", (sof | eof) & ~sample_strobe, 1'b0);
      if (sample_strobe) expect_ev(K_SAMP, sof, eof, "sample");
      if (cmd_done)      expect_ev(K_DONE, 1'b0, 1'b0, "cmd_done");
      if (err_chain)     expect_ev(K_CHAIN, 1'b0, 1'b0, "err_chain");
      if (err_late)      expect_ev(K_LATE, 1'b0, 1'b0, "err_late");
      if (cmd_overflow) begin
        checks++;
        if (ovf_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_overflow actual=1 required=0 at %0t", $time);
        end else void'(ovf_q.pop_front());
      end
    end
  end

  function automatic logic [31:0] mkw(input bit imm, input bit chain, input bit reload,
                                       input bit stop, input int nl);
    logic [31:0] w;
    w = {imm, chain, reload, stop, 28'(nl)};
    return w;
  endfunction

  function automatic cmd_t mkc(input logic [31:0] w, input logic [63:0] t, input bit late);
    cmd_t c;
    c.w = w; c.t = t; c.late = late;
    return c;
  endfunction

  task automatic exp_ev(input int kind, input bit s, input bit e);
    ev_t x;
    x.kind = kind; x.sof = s; x.eof = e;
    exp_q.push_back(x);
  endtask

  // Reference: walk the command list as queued words, assuming all are queued before any eof.
  task automatic model_scn();
    int   i = 0;
    int   nl;
    bit   busy;
    cmd_t c;
    while (i < scn.size()) begin
      c = scn[i]; i++;
      if (c.w[28] || c.w[27:0] == 28'd0) begin exp_ev(K_DONE, 0, 0); continue; end
`ifdef RX_CMD_LATE_ERR_EN
      if (c.late) begin exp_ev(K_LATE, 0, 0); continue; end
`endif
      busy = 1'b1;
      while (busy) begin
        nl = int'(c.w[27:0]);
        for (int k = 0; k < nl; k++) exp_ev(K_SAMP, k == 0, k == nl - 1);
        if (!c.w[30]) begin exp_ev(K_DONE, 0, 0); busy = 1'b0; end
        else if (i < scn.size()) begin c = scn[i]; i++; end
        else begin exp_ev(K_CHAIN, 0, 0); busy = 1'b0; end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [31:0] w, input logic [63:0] t);
    cif.command_i = w; cif.time_i = t; cif.store_command = 1'b1;
    tick();
    cif.store_command = 1'b0;
  endtask

  task automatic wait_run();
    int n = 0;
    while (!run && n < 200) begin @(negedge clk); n++; end
    check("run_rise", run, 1'b1);
    tick();
  endtask

  // mode 0: random sample_valid, 1: always valid, 2: never valid
  task automatic drain(input int mode);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      sample_valid = (mode == 0) ? 1'($urandom % 2) : (mode == 1);
      tick(); n++;
    end
    sample_valid = 1'b0;
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=%0d required=0 pending events", exp_q.size());
      exp_q.delete();
    end
    repeat (3) tick();
    check("idle_run", run, 1'b0);
    check("idle_level", fifo_level, 4'd0);
  endtask

  task automatic run_scn(input int mode);
    model_scn();
    foreach (scn[j]) push(scn[j].w, scn[j].t);
    drain(mode);
  endtask

  initial begin
    int cnt, nsc, r;
    bit prev_chain;
    logic [63:0] t;
    reset = 1'b1; sample_valid = 1'b0;
    cif.command_i = '0; cif.time_i = '0; cif.store_command = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_run", run, 0);       check("rst_strobe", sample_strobe, 0);
    check("rst_sof", sof, 0);       check("rst_eof", eof, 0);
    check("rst_done", cmd_done, 0); check("rst_late", err_late, 0);
    check("rst_chain", err_chain, 0); check("rst_ovf", cmd_overflow, 0);
    check("rst_level", fifo_level, 0);
    reset = 1'b0;
    tick();

    // 1: send_imm, 16 lines, run three cycles after the push
    scn = '{mkc(mkw(1, 0, 0, 0, 16), 64'd0, 0)};
    model_scn();
    push(scn[0].w, 64'd0);
    @(negedge clk);
    @(negedge clk); check("lat_n2_run", run, 0);
    @(negedge clk); check("lat_n3_run", run, 1);
    tick();
    drain(0);

    // 2: timed start, then a late command
    t = vita_time + 64'd40;
    scn = '{mkc(mkw(0, 0, 0, 0, 3), t, 0)};
    model_scn();
    push(scn[0].w, t);
    cnt = 0;
    while (vita_time != t && cnt < 200) begin @(negedge clk); cnt++; end
    check("timed_hold_run", run, 0);
    @(negedge clk); check("timed_start_run", run, 1);
    tick();
    drain(0);
    scn = '{mkc(mkw(0, 0, 0, 0, 3), 64'd1, 1)};
    run_scn(0);

    // 3: chain A(8)+B(4) contiguous, then chain with empty FIFO
    scn = '{mkc(mkw(1, 1, 0, 0, 8), 64'd0, 0), mkc(mkw(1, 0, 0, 0, 4), 64'd0, 0)};
    model_scn();
    push(scn[0].w, 64'd0); push(scn[1].w, 64'd0);
    wait_run();
    sample_valid = 1'b1;
    cnt = 0;
    for (int k = 0; k < 100; k++) begin @(negedge clk); if (!run) break; cnt++; end
    check("chain_run_cycles", cnt, 12);
    tick();
    drain(2);
    scn = '{mkc(mkw(1, 1, 0, 0, 8), 64'd0, 0)};
    run_scn(0);

    // 4: reload of 5 lines, stop pushed after 12 samples
    for (int k = 1; k <= 12; k++) exp_ev(K_SAMP, (k % 5) == 1, (k % 5) == 0);
    exp_ev(K_DONE, 0, 0);
    push(mkw(1, 1, 1, 0, 5), 64'd0);
    wait_run();
    sample_valid = 1'b1;
    cnt = 0;
    for (int k = 0; k < 100 && cnt < 12; k++) begin @(negedge clk); if (sample_strobe) cnt++; end
    check("reload_samples", cnt, 12);
    tick();
    sample_valid = 1'b0;
    push(mkw(0, 0, 0, 1, 0), 64'd0);
    drain(2);

    // 5: fill during RUN, overflow, then push and pop in the same cycle
    scn = '{mkc(mkw(1, 1, 0, 0, 2), 64'd0, 0)};
    for (int k = 0; k < 9; k++) scn.push_back(mkc(mkw(1, 0, 0, 0, 1), 64'd0, 0));
    model_scn();
    push(scn[0].w, 64'd0);
    wait_run();
    for (int k = 1; k <= 8; k++) push(scn[k].w, 64'd0);
    check("full_level", fifo_level, 4'd8);
    ovf_q.push_back(1'b1);
    push(mkw(1, 0, 0, 0, 7), 64'd0);
    check("ovf_level", fifo_level, 4'd8);
    sample_valid = 1'b1;
    tick();
    cif.command_i = scn[9].w; cif.time_i = 64'd0; cif.store_command = 1'b1;
    tick();
    cif.store_command = 1'b0; sample_valid = 1'b0;
    check("pushpop_level", fifo_level, 4'd8);
    drain(0);
    check("ovf_seen", ovf_q.size(), 0);

    // 6: reset at sample 3 of 16, then a clean command
    exp_ev(K_SAMP, 1, 0); exp_ev(K_SAMP, 0, 0); exp_ev(K_SAMP, 0, 0);
    push(mkw(1, 0, 0, 0, 16), 64'd0);
    wait_run();
    sample_valid = 1'b1;
    cnt = 0;
    for (int k = 0; k < 100 && cnt < 3; k++) begin @(negedge clk); if (sample_strobe) cnt++; end
    #1 reset = 1'b1; sample_valid = 1'b0;
    #1;
    check("mid_rst_run", run, 0);   check("mid_rst_strobe", sample_strobe, 0);
    check("mid_rst_eof", eof, 0);   check("mid_rst_done", cmd_done, 0);
    check("mid_rst_level", fifo_level, 0);
    tick(); tick();
    reset = 1'b0;
    check("mid_rst_pending", exp_q.size(), 0);
    tick();
    scn = '{mkc(mkw(1, 0, 0, 0, 2), 64'd0, 0)};
    run_scn(0);

    // Randomized command lists
    for (int it = 0; it < 25; it++) begin
      scn.delete();
      nsc = 1 + int'($urandom % 4);
      prev_chain = 1'b0;
      for (int j = 0; j < nsc; j++) begin
        cmd_t c;
        int nl;
        bit ch;
        r  = (j == 0) ? int'($urandom % 3) : (($urandom % 4) == 0 ? 2 : 0);
        ch = 1'($urandom % 2);
        nl = prev_chain ? 1 + int'($urandom % 6) : int'($urandom % 7);
        if (r == 0)      c = mkc(mkw(1, ch, 0, 0, nl), 64'd0, 0);
        else if (r == 1) c = mkc(mkw(0, ch, 0, 0, nl), vita_time + 64'(20 + $urandom % 30), 0);
        else             c = mkc(mkw(0, ch, 0, 0, nl), 64'd1, 1);
        scn.push_back(c);
        prev_chain = ch;
      end
      run_scn(0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
